hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage RV32I core. It drives the stall and flush controls of the F/D/E/M/W pipeline registers, including the Decode register's i_StallD/i_FlushD, and the operand-forwarding selects for the Execute stage. It resolves three cases:
- load-use hazards;
- taken branches and jumps;
- multi-cycle data-memory waits, which freeze the pipeline.

It also keeps sticky timeout detection and saturating performance counters.

## Interface
Parameters:
- P_TIMEOUT, 16, consecutive memory-wait cycles before o_MemTimeout is set (legal range 2..255).
- P_CNT_W, 32, width of the performance counters.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Reset  in  1  reset, asynchronous, active-low.
- i_Rs1D, i_Rs2D  in  5  source registers of the Decode-stage instruction.
- i_Rs1E, i_Rs2E, i_RdE  in  5  source and destination registers in Execute.
- i_ResultSrcE0  in  1  Execute-stage instruction is a load.
- i_PCSrcE  in  1  taken branch or jump resolved in Execute.
- i_RdM, i_RdW  in  5  destination registers in Memory and Writeback.
- i_RegWriteM, i_RegWriteW  in  1  register-write enables in Memory and Writeback.
- i_MemReqM  in  1  Memory-stage instruction is accessing data memory.
- i_MemReadyM  in  1  data memory completes the access this cycle.
- i_ClrCounters  in  1  synchronous clear of counters and timeout.
- o_StallF, o_StallD, o_StallE, o_StallM  out  1  hold the corresponding pipeline register.
- o_FlushD, o_FlushE, o_FlushW  out  1  bubble the corresponding pipeline register.
- o_ForwardAE, o_ForwardBE  out  2  ALU operand select: 00 = register file, 01 = ResultW, 10 = ALUResultM.
- o_MemTimeout  out  1  sticky memory-wait timeout flag.
- o_StallCycles, o_FlushCount  out  P_CNT_W  performance counters.

## Operation
Definitions:
- lwStall = i_ResultSrcE0 & (i_RdE != 0) & (i_RdE == i_Rs1D | i_RdE == i_Rs2D).
- freeze = i_MemReqM & ~i_MemReadyM.

When freeze = 1 (highest priority):
- o_StallF, o_StallD, o_StallE and o_StallM are 1; o_FlushW is 1.
- o_FlushD and o_FlushE are 0, even when i_PCSrcE = 1. The branch is still held in Execute and takes effect once the freeze ends.

When freeze = 0:
- o_StallF = o_StallD = lwStall.
- o_FlushD = i_PCSrcE.
- o_FlushE = lwStall | i_PCSrcE.
- o_StallE, o_StallM and o_FlushW are 0.

Forwarding (o_ForwardAE; o_ForwardBE is identical using i_Rs2E):
- 10 if i_RegWriteM & i_RdM != 0 & i_RdM == i_Rs1E.
- Else 01 if i_RegWriteW & i_RdW != 0 & i_RdW == i_Rs1E.
- Else 00.
- The Memory stage wins over Writeback.
- Forwarding is evaluated identically whether or not the pipeline is frozen.

Wait FSM and timeout:
- The FSM has states IDLE and WAIT, plus a wait counter wcnt (8 bits).
- IDLE: if freeze, go to WAIT with wcnt = 1.
- WAIT: if i_MemReadyM or ~i_MemReqM, go to IDLE with wcnt = 0. Otherwise wcnt increments, saturating at 255.
- o_MemTimeout sets on the edge where wcnt reaches P_TIMEOUT, i.e. after P_TIMEOUT consecutive freeze cycles.
- Once set, o_MemTimeout stays set until reset or i_ClrCounters. The freeze itself continues regardless of the timeout.

Counters:
- o_StallCycles increments every cycle in which o_StallD = 1, for any cause.
- o_FlushCount increments every cycle in which o_FlushD = 1.
- Both saturate at all-ones and never wrap.
- i_ClrCounters zeroes both counters and o_MemTimeout, and takes priority over increment. It does not affect the FSM.

## Timing
- All stall, flush and forward outputs are combinational from the current inputs, with zero-cycle latency.
- The FSM, wcnt, o_MemTimeout and both counters are registered on the rising edge of i_Clk.
- Reset (i_Reset low, asynchronous): FSM = IDLE, wcnt = 0, o_MemTimeout = 0, counters = 0.
- Reset asserted mid-wait: the FSM returns to IDLE immediately. The combinational outputs still follow the inputs.
- lwStall and i_PCSrcE together with no freeze: o_StallF = o_StallD = 1, o_FlushD = 1, o_FlushE = 1. Each counter increments once that cycle.
- i_MemReqM & i_MemReadyM in the same cycle: no freeze and no WAIT entry.

## Test plan
- Load x5 in Execute, Decode reads x5 as rs2 -> o_StallF = o_StallD = o_FlushE = 1 for one cycle; o_StallCycles goes 0 -> 1.
- i_RdM = i_RdW = 7, both write enables 1, i_Rs1E = 7 -> o_ForwardAE = 10. Same with i_RdM = 0 -> o_ForwardAE = 01. With i_Rs1E = 0 -> 00.
- i_PCSrcE = 1 with no freeze -> o_FlushD = o_FlushE = 1, stalls 0; o_FlushCount increments by 1.
- i_MemReqM = 1 held with i_MemReadyM = 0 for 3 cycles, then ready -> F/D/E/M stalled and o_FlushW = 1 for exactly 3 cycles; a concurrent i_PCSrcE produces no flush until the freeze ends.
- Wait of P_TIMEOUT = 16 cycles -> o_MemTimeout rises after the 16th freeze cycle and stays set after ready; i_ClrCounters clears it.
- Force counters near saturation (P_CNT_W = 4) with 20 stall cycles -> o_StallCycles = 15; async reset mid-wait -> all registered outputs 0 and FSM IDLE immediately.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding control for the 5-stage RV32I pipeline.
// Ports:
//   i_Clk, i_Reset                - clock (rising edge), async active-low reset
//   i_Rs1D/i_Rs2D                 - Decode source registers
//   i_Rs1E/i_Rs2E/i_RdE           - Execute source/destination registers
//   i_ResultSrcE0, i_PCSrcE       - Execute is a load / taken branch or jump
//   i_RdM/i_RdW, i_RegWriteM/W    - Memory/Writeback destination and write enables
//   i_MemReqM, i_MemReadyM        - data-memory request and completion
//   i_ClrCounters                 - synchronous clear of counters and timeout flag
//   o_Stall*/o_Flush*             - pipeline register hold/bubble controls (combinational)
//   o_ForwardAE/BE                - ALU operand selects (combinational)
//   o_MemTimeout                  - sticky memory-wait timeout
//   o_StallCycles, o_FlushCount   - saturating performance counters
module hazard_unit #(
  parameter int unsigned P_TIMEOUT = 16,
  parameter int unsigned P_CNT_W   = 32
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [4:0]         i_Rs1D,
  input  logic [4:0]         i_Rs2D,
  input  logic [4:0]         i_Rs1E,
  input  logic [4:0]         i_Rs2E,
  input  logic [4:0]         i_RdE,
  input  logic               i_ResultSrcE0,
  input  logic               i_PCSrcE,
  input  logic [4:0]         i_RdM,
  input  logic [4:0]         i_RdW,
  input  logic               i_RegWriteM,
  input  logic               i_RegWriteW,
  input  logic               i_MemReqM,
  input  logic               i_MemReadyM,
  input  logic               i_ClrCounters,
  output logic               o_StallF,
  output logic               o_StallD,
  output logic               o_StallE,
  output logic               o_StallM,
  output logic               o_FlushD,
  output logic               o_FlushE,
  output logic               o_FlushW,
  output logic [1:0]         o_ForwardAE,
  output logic [1:0]         o_ForwardBE,
  output logic               o_MemTimeout,
  output logic [P_CNT_W-1:0] o_StallCycles,
  output logic [P_CNT_W-1:0] o_FlushCount
);

  localparam int unsigned WCNT_W = 8;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic              lw_stall;
  logic              freeze;
  logic [0:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_q, timeout_d;
  logic [P_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [P_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Memory stage has the younger result, so it wins over Writeback.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))      fwd_sel = 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) fwd_sel = 2'b01;
    else                                              fwd_sel = 2'b00;
  endfunction

  assign lw_stall = i_ResultSrcE0 && (i_RdE != 5'd0) &&
                    ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
  assign freeze   = i_MemReqM && !i_MemReadyM;

  // Stall/flush control; a memory freeze holds everything, including a pending branch.
  always_comb begin
    o_StallF = 1'b0;
    o_StallD = 1'b0;
    o_StallE = 1'b0;
    o_StallM = 1'b0;
    o_FlushD = 1'b0;
    o_FlushE = 1'b0;
    o_FlushW = 1'b0;
    if (freeze) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_StallE = 1'b1;
      o_StallM = 1'b1;
      o_FlushW = 1'b1;
    end else begin
      o_StallF = lw_stall;
      o_StallD = lw_stall;
      o_FlushD = i_PCSrcE;
      o_FlushE = lw_stall || i_PCSrcE;
    end
  end

  assign o_ForwardAE = fwd_sel(i_Rs1E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
  assign o_ForwardBE = fwd_sel(i_Rs2E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);

  // Wait FSM, sticky timeout and saturating counters.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (freeze) begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!freeze) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q != '1) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase

    // Set only on the edge where wcnt arrives at the threshold, not while parked there.
    if (i_ClrCounters) begin
      timeout_d = 1'b0;
    end else if ((wcnt_d == WCNT_W'(P_TIMEOUT)) && (wcnt_q != WCNT_W'(P_TIMEOUT))) begin
      timeout_d = 1'b1;
    end

    if (i_ClrCounters) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (o_StallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + P_CNT_W'(1);
      if (o_FlushD && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + P_CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_MemTimeout  = timeout_q;
  assign o_StallCycles = stall_cnt_q;
  assign o_FlushCount  = flush_cnt_q;

endmodule
